// File: rtl/link_ctrl_pkg.sv
// Shared types and constants for the link bring-up controller.
package link_ctrl_pkg;

    localparam int STATE_W     = 3;
    // ERR_CNT is stale for this many cycles starting with a CLR pulse
    localparam int CLR_IGN_CYC = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_INIT       = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_UP         = 3'd4,
        ST_FAIL       = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/link_cycle_timer.sv
// Up-counting cycle timer: synchronous clear, holds at the terminal value.
module link_cycle_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != i_term) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/link_train_ctrl.sv
// Link bring-up/supervision FSM: PHY init, alignment wait, error probation, retrain.
// Optional macro LINK_ERR_WINDOW_EN turns the UP-state error check into a per-window rate.
//
// state      | meaning
// IDLE       | link down, all outputs 0, retry count cleared
// INIT       | PHY_INIT high for INIT_CYC cycles, CLR on entry
// WAIT_ALIGN | PHY_INIT high, waiting for ALIGNED up to ALIGN_TO cycles
// SETTLE     | error-free probation for SETTLE_CYC cycles, CLR on entry
// UP         | link operational, supervising ALIGNED and ERR_CNT
// FAIL       | retries exhausted, held until EN drops
module link_train_ctrl
    import link_ctrl_pkg::*;
#(
    parameter int INIT_CYC   = 64,
    parameter int ALIGN_TO   = 1024,
    parameter int SETTLE_CYC = 256,
    parameter int ERR_TH     = 4,
    parameter int MAX_RETRY  = 3
`ifdef LINK_ERR_WINDOW_EN
    ,
    parameter int ERR_WIN    = 4096
`endif
) (
    input  logic               i_rstx,
    input  logic               i_clk,
    input  logic               i_en,
    input  logic               i_aligned,
    input  logic [7:0]         i_err_cnt,
    output logic               o_phy_init,
    output logic               o_clr,
    output logic               o_link_up,
    output logic               o_link_fail,
    output logic [3:0]         o_retry_cnt,
    output logic [STATE_W-1:0] o_state
);

    localparam int CNT_W = $clog2(max3(INIT_CYC, ALIGN_TO, SETTLE_CYC));
    localparam logic [CNT_W-1:0] INIT_TERM   = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] ALIGN_TERM  = CNT_W'(ALIGN_TO - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_phy_init;
    logic             r_clr;
    logic             r_link_up;
    logic             r_link_fail;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_inc;
    logic             w_retry;
    logic             w_err_hit;
    logic             w_up_err_ok;
    logic             w_win_wrap;
    logic             w_tmr_clr;
    logic             w_tc;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_term;

    always_comb begin
        w_term = '0;
        case (r_state)
            ST_INIT:       w_term = INIT_TERM;
            ST_WAIT_ALIGN: w_term = ALIGN_TERM;
            ST_SETTLE:     w_term = SETTLE_TERM;
            default:       w_term = '0;
        endcase
    end

    assign w_tmr_clr = (w_nxt != r_state);

    link_cycle_timer #(.W(CNT_W)) u_state_tmr (
        .i_clk   (i_clk),
        .i_rst_n (i_rstx),
        .i_clr   (w_tmr_clr),
        .i_term  (w_term),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

`ifdef LINK_ERR_WINDOW_EN
    localparam int WIN_W = $clog2(ERR_WIN);
    logic [WIN_W-1:0] w_win_cnt;
    logic             w_win_tc;

    // Held at zero outside UP; wraps modulo ERR_WIN while UP
    link_cycle_timer #(.W(WIN_W)) u_win_tmr (
        .i_clk   (i_clk),
        .i_rst_n (i_rstx),
        .i_clr   ((r_state != ST_UP) || w_win_tc),
        .i_term  (WIN_W'(ERR_WIN - 1)),
        .o_cnt   (w_win_cnt),
        .o_tc    (w_win_tc)
    );

    assign w_win_wrap  = w_win_tc && (r_state == ST_UP);
    assign w_up_err_ok = (w_win_cnt >= WIN_W'(CLR_IGN_CYC));
`else
    assign w_win_wrap  = 1'b0;
    assign w_up_err_ok = 1'b1;
`endif

    assign w_err_hit   = (i_err_cnt >= 8'(ERR_TH));
    assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

    always_comb begin
        w_nxt   = r_state;
        w_retry = 1'b0;
        if (!i_en) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_nxt = ST_INIT;
                ST_INIT:       if (w_tc) w_nxt = ST_WAIT_ALIGN;
                ST_WAIT_ALIGN: begin
                    if (i_aligned)  w_nxt   = ST_SETTLE;
                    else if (w_tc)  w_retry = 1'b1;
                end
                ST_SETTLE: begin
                    if (!i_aligned || ((w_cnt >= CNT_W'(CLR_IGN_CYC)) && w_err_hit))
                        w_retry = 1'b1;
                    else if (w_tc)
                        w_nxt = ST_UP;
                end
                ST_UP:         if (!i_aligned || (w_up_err_ok && w_err_hit)) w_retry = 1'b1;
                ST_FAIL:       w_nxt = ST_FAIL;
                default:       w_nxt = ST_IDLE;
            endcase
            if (w_retry)
                w_nxt = (w_retry_inc == 4'(MAX_RETRY)) ? ST_FAIL : ST_INIT;
        end
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge i_clk or negedge i_rstx) begin
        if (!i_rstx) begin
            r_state     <= ST_IDLE;
            r_phy_init  <= 1'b0;
            r_clr       <= 1'b0;
            r_link_up   <= 1'b0;
            r_link_fail <= 1'b0;
            r_retry     <= 4'd0;
        end else begin
            r_state     <= w_nxt;
            r_phy_init  <= (w_nxt == ST_INIT) || (w_nxt == ST_WAIT_ALIGN);
            r_clr       <= (((w_nxt == ST_INIT) || (w_nxt == ST_SETTLE)) && w_tmr_clr)
                           || (w_win_wrap && (w_nxt == ST_UP));
            r_link_up   <= (w_nxt == ST_UP);
            r_link_fail <= (w_nxt == ST_FAIL);
            if (w_nxt == ST_IDLE)
                r_retry <= 4'd0;
            else if (w_retry)
                r_retry <= w_retry_inc;
        end
    end

    assign o_phy_init  = r_phy_init;
    assign o_clr       = r_clr;
    assign o_link_up   = r_link_up;
    assign o_link_fail = r_link_fail;
    assign o_retry_cnt = r_retry;
    assign o_state     = r_state;

endmodule

// File: tb/tb_link_train_ctrl.sv
// Directed bench for link_train_ctrl: bring-up, retrain, timeout/FAIL, EN priority, async reset.
module tb_link_train_ctrl;

    logic       clk = 1'b0;
    logic       rstx;
    logic       en;
    logic       aligned;
    logic [7:0] err_cnt;
    logic       phy_init;
    logic       clr;
    logic       link_up;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int phy_hi = 0;

    always #5 clk = ~clk;

    link_train_ctrl dut (
        .i_rstx      (rstx),
        .i_clk       (clk),
        .i_en        (en),
        .i_aligned   (aligned),
        .i_err_cnt   (err_cnt),
        .o_phy_init  (phy_init),
        .o_clr       (clr),
        .o_link_up   (link_up),
        .o_link_fail (link_fail),
        .o_retry_cnt (retry_cnt),
        .o_state     (state)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (phy_init) phy_hi++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstx    = 1'b0;
        en      = 1'b0;
        aligned = 1'b0;
        err_cnt = 8'd0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_phy", phy_init, 0);
        chk("rst_clr", clr, 0);
        chk("rst_up", link_up, 0);
        chk("rst_fail", link_fail, 0);
        chk("rst_retry", retry_cnt, 0);
        @(posedge clk);
        #1;
        rstx = 1'b1;
        step(1);
        chk("idle_no_en", state, 0);

        // normal bring-up, ALIGNED seen on the 10th WAIT_ALIGN cycle
        phy_hi = 0;
        en = 1'b1;
        step(1);
        chk("init_state", state, 1);
        chk("init_clr", clr, 1);
        step(1);
        chk("init_clr_1cyc", clr, 0);
        step(62);
        chk("init_last", state, 1);
        step(1);
        chk("wait_state", state, 2);
        step(9);
        aligned = 1'b1;
        step(1);
        chk("settle_state", state, 3);
        chk("settle_clr", clr, 1);
        chk("settle_phy", phy_init, 0);
        chk("phy_hi_cycles", phy_hi, 74);
        step(255);
        chk("settle_last", state, 3);
        step(1);
        chk("up_state", state, 4);
        chk("up_link", link_up, 1);
        chk("up_retry", retry_cnt, 0);

        // UP: one-cycle alignment loss retrains
        aligned = 1'b0;
        step(1);
        aligned = 1'b1;
        chk("drop_state", state, 1);
        chk("drop_link", link_up, 0);
        chk("drop_phy", phy_init, 1);
        chk("drop_retry", retry_cnt, 1);
        step(64 + 1 + 256);
        chk("reup_state", state, 4);
        err_cnt = 8'd3;
        step(5);
        chk("err3_state", state, 4);
        chk("err3_link", link_up, 1);
        err_cnt = 8'd4;
        step(1);
        err_cnt = 8'd0;
        chk("err4_state", state, 1);
        chk("err4_retry", retry_cnt, 2);
        en = 1'b0;
        step(1);
        chk("off_state", state, 0);
        chk("off_retry", retry_cnt, 0);

        // errors in SETTLE, then clean attempt with stale ERR_CNT in first 2 cycles
        en = 1'b1;
        step(1 + 64 + 1);
        chk("s_err_settle", state, 3);
        step(50);
        err_cnt = 8'd4;
        step(1);
        err_cnt = 8'd0;
        chk("s_err_state", state, 1);
        chk("s_err_retry", retry_cnt, 1);
        step(64 + 1);
        chk("s2_settle", state, 3);
        err_cnt = 8'd4;
        step(2);
        err_cnt = 8'd0;
        chk("s2_ignore", state, 3);
        step(253);
        chk("s2_last", state, 3);
        step(1);
        chk("s2_up", state, 4);
        chk("s2_retry", retry_cnt, 1);
        en = 1'b0;
        step(1);
        chk("s2_idle", state, 0);

        // alignment timeout x3 -> FAIL
        aligned = 1'b0;
        en = 1'b1;
        step(1 + 64);
        chk("to_wait", state, 2);
        step(1023);
        chk("to_wait_last", state, 2);
        step(1);
        chk("to1_state", state, 1);
        chk("to1_retry", retry_cnt, 1);
        step(1088);
        chk("to2_state", state, 1);
        chk("to2_retry", retry_cnt, 2);
        step(1088);
        chk("fail_state", state, 5);
        chk("fail_flag", link_fail, 1);
        chk("fail_phy", phy_init, 0);
        chk("fail_retry", retry_cnt, 3);
        step(3);
        chk("fail_hold", state, 5);
        en = 1'b0;
        step(1);
        chk("fail_idle", state, 0);
        chk("fail_idle_retry", retry_cnt, 0);
        chk("fail_idle_flag", link_fail, 0);

        // EN=0 on the timeout cycle wins
        en = 1'b1;
        step(1 + 64 + 1023);
        chk("pri_wait", state, 2);
        en = 1'b0;
        step(1);
        chk("pri_idle", state, 0);
        chk("pri_retry", retry_cnt, 0);

        // ALIGNED on the timeout cycle wins
        en = 1'b1;
        step(1 + 64 + 1023);
        aligned = 1'b1;
        step(1);
        chk("alw_state", state, 3);
        chk("alw_retry", retry_cnt, 0);
        step(256);
        chk("alw_up", link_up, 1);

        // async reset while UP
        #3;
        rstx = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_up", link_up, 0);
        chk("ar_phy", phy_init, 0);
        chk("ar_clr", clr, 0);
        step(2);
        rstx = 1'b1;
        step(1);
        chk("ar_restart", state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
